// File: rtl/fifo_rd_pkg.sv
// Shared definitions for the FIFO burst reader.
//   state_e     : burst FSM states (IDLE, RUN, DRAIN, DONE)
//   SKID_DEPTH  : entries in the skid buffer behind the FIFO read port
//   SKID_CNT_W  : width of an occupancy count 0..SKID_DEPTH
//   SKID_PTR_W  : width of a skid buffer slot pointer
//   skid_ptr_next() : wrapping pointer increment
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int SKID_PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  function automatic logic [SKID_PTR_W-1:0] skid_ptr_next(input logic [SKID_PTR_W-1:0] p);
    return (p == SKID_PTR_W'(SKID_DEPTH - 1)) ? '0 : p + SKID_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// Small skid buffer holding bytes returned by the FIFO until the downstream
// stream accepts them. Each entry carries the data byte and its last flag.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   push_i, push_data_i,
//   push_last_i              : write one entry (ignored when full and not popping)
//   pop_i                    : remove the head entry (ignored when empty)
//   flush_i                  : discard all entries; overrides push/pop
//   head_data_o, head_last_o : oldest entry (meaningful only when count_o != 0)
//   count_o                  : current occupancy
module fifo_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_W-1:0]     push_data_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic [DATA_W-1:0]     head_data_o,
  output logic                  head_last_o,
  output logic [SKID_CNT_W-1:0] count_o
);

  logic [DATA_W-1:0]     data_q [SKID_DEPTH];
  logic                  last_q [SKID_DEPTH];
  logic [SKID_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [SKID_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [SKID_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != SKID_CNT_W'(SKID_DEPTH)) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = skid_ptr_next(wr_ptr_q);
      if (do_pop)  rd_ptr_d = skid_ptr_next(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + SKID_CNT_W'(1);
        2'b01:   count_d = count_q - SKID_CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push && !flush_i) begin
        data_q[wr_ptr_q] <= push_data_i;
        last_q[wr_ptr_q] <= push_last_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_data_o = data_q[rd_ptr_q];
  assign head_last_o = last_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst consumer for an asynchronous FIFO (read_clk domain).
// On a start pulse it pulls exactly burst_len bytes from the FIFO, hides the
// FIFO's one-cycle read latency behind a two-entry skid buffer and forwards the
// bytes on a valid/ready stream, flagging the final byte with out_last.
// Ports:
//   read_clk, reset          : clock, asynchronous active-low reset
//   start, burst_len         : burst request (sampled in IDLE only)
//   abort                    : terminate the running burst
//   fifo_empty, fifo_data    : FIFO status and read data (1-cycle latency)
//   fifo_rd_en               : FIFO read enable
//   out_valid/out_ready/
//   out_data/out_last        : downstream byte stream
//   busy, done               : activity flag, 1-cycle completion pulse
//   xfer_count               : bytes accepted downstream in current/last burst
//   dbg_state                : current FSM state, for observation only
//
// Stream handshake: a byte transfers on every rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_valid, out_data and
// out_last stay unchanged until that transfer happens (abort excepted).
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              read_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              abort,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  xfer_count,
  output state_e            dbg_state
);

  state_e                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      issued_q, issued_d;
  logic [LEN_W-1:0]      xfer_q, xfer_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [SKID_CNT_W-1:0] skid_count;
  logic [DATA_W-1:0]     head_data;
  logic                  head_last;
  logic                  pop, push, flush;
  logic [LEN_W-1:0]      issued_inc;
  logic [2:0]            occ_sum;
  logic [2:0]            occ_limit;

  assign out_valid  = (skid_count != '0);
  assign pop        = out_valid && out_ready;
  assign flush      = abort && ((state_q == RUN) || (state_q == DRAIN));
  // The byte read last cycle lands in the buffer now unless abort discards it.
  assign push       = inflight_q && !flush;
  assign issued_inc = issued_q + LEN_W'(1);

  // Bytes held plus the byte still on its way from the FIFO must fit in the
  // buffer by the time the new read returns. A byte leaving this cycle frees
  // a slot, which keeps one read per cycle going under steady out_ready.
  assign occ_sum   = 3'(skid_count) + 3'(inflight_q);
  assign occ_limit = 3'(SKID_DEPTH) + 3'(pop);

  assign fifo_rd_en = (state_q == RUN) && (issued_q < len_q) && !fifo_empty &&
                      (occ_sum < occ_limit);

  assign out_data   = head_data;
  assign out_last   = out_valid && head_last;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);
  assign xfer_count = xfer_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d         = state_q;
    len_d           = len_q;
    issued_d        = issued_q;
    xfer_d          = xfer_q;
    inflight_d      = fifo_rd_en && !flush;
    inflight_last_d = (issued_inc == len_q);

    if (pop) xfer_d = xfer_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          issued_d = '0;
          xfer_d   = '0;
          if (burst_len == '0) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            len_d   = burst_len;
          end
        end
      end
      RUN: begin
        if (abort) begin
          state_d = DONE;
        end else if (fifo_rd_en) begin
          issued_d = issued_inc;
          if (issued_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) state_d = DONE;
        else if (pop && out_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge read_clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      len_q           <= '0;
      issued_q        <= '0;
      xfer_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      xfer_q          <= xfer_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fifo_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk_i       (read_clk),
    .rst_ni      (reset),
    .push_i      (push),
    .push_data_i (fifo_data),
    .push_last_i (inflight_last_q),
    .pop_i       (pop),
    .flush_i     (flush),
    .head_data_o (head_data),
    .head_last_o (head_last),
    .count_o     (skid_count)
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
module tb_fifo_burst_reader;
  import fifo_rd_pkg::*;

  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  // ---------------- clock / reset / DUT ----------------
  logic              read_clk   = 1'b0;
  logic              reset      = 1'b0;
  logic              start      = 1'b0;
  logic [LEN_W-1:0]  burst_len  = '0;
  logic              abort      = 1'b0;
  logic              fifo_empty = 1'b1;
  logic [DATA_W-1:0] fifo_data  = '0;
  logic              out_ready  = 1'b0;
  logic              fifo_rd_en;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic [LEN_W-1:0]  xfer_count;
  state_e            dbg_state;

  always #5 read_clk = ~read_clk;

  fifo_burst_reader #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W)
  ) dut (
    .read_clk   (read_clk),
    .reset      (reset),
    .start      (start),
    .burst_len  (burst_len),
    .abort      (abort),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .xfer_count (xfer_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- FIFO model ----------------
  // Bytes queued by the stimulus in pend_q enter the FIFO at the next edge.
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] pend_q[$];

  always @(posedge read_clk) begin
    if (fifo_rd_en && !fifo_empty && (fifo_q.size() > 0)) fifo_data <= fifo_q.pop_front();
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
  end

  // ---------------- stream / read monitor ----------------
  logic [DATA_W:0] got_q[$];
  logic [DATA_W:0] exp_q[$];
  int   rd_cnt         = 0;
  logic rd_while_empty = 1'b0;

  always @(negedge read_clk) begin
    if (reset) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (fifo_rd_en && !fifo_empty) rd_cnt++;
      if (fifo_rd_en && fifo_empty) rd_while_empty = 1'b1;
    end
  end

  // ---------------- scoreboard helpers ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int got_base = 0;
  int rd_mark  = 0;
  int rd_abort = 0;
  logic found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_fifo(input logic [DATA_W-1:0] d);
    pend_q.push_back(d);
  endtask

  task automatic exp_b(input logic [DATA_W-1:0] d, input logic l);
    exp_q.push_back({l, d});
  endtask

  task automatic check_stream(input string tag);
    logic [31:0] obs;
    check({tag, "_count"}, 32'(got_q.size() - got_base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (got_base + i < got_q.size()) ? 32'(got_q[got_base + i]) : 32'hDEAD;
      check($sformatf("%s_byte%0d", tag, i), obs, 32'(exp_q[i]));
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic start_burst(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    found = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state
    tickn(2);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_xfer", 32'(xfer_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b1;
    tick();

    // T1 basic burst of 3
    push_fifo(8'hA1); push_fifo(8'hB2); push_fifo(8'hC3);
    tickn(2);
    out_ready = 1'b1;
    rd_mark = rd_cnt;
    start_burst(8'd3);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("t1_b0_valid", 32'(out_valid), 32'd1);
    check("t1_b0_data", 32'(out_data), 32'hA1);
    check("t1_b0_last", 32'(out_last), 32'd0);
    tick();
    check("t1_b1_data", 32'(out_data), 32'hB2);
    check("t1_b1_valid", 32'(out_valid), 32'd1);
    tick();
    check("t1_b2_data", 32'(out_data), 32'hC3);
    check("t1_b2_last", 32'(out_last), 32'd1);
    tick();
    check("t1_done", 32'(done), 32'd1);
    check("t1_xfer", 32'(xfer_count), 32'd3);
    check("t1_valid_after", 32'(out_valid), 32'd0);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    check("t1_reads", 32'(rd_cnt - rd_mark), 32'd3);
    exp_b(8'hA1, 1'b0); exp_b(8'hB2, 1'b0); exp_b(8'hC3, 1'b1);
    check_stream("t1_stream");

    // T2 backpressure, len 4
    push_fifo(8'h11); push_fifo(8'h22); push_fifo(8'h33); push_fifo(8'h44);
    tickn(2);
    out_ready = 1'b0;
    rd_mark = rd_cnt;
    start_burst(8'd4);
    tickn(9);
    check("t2_reads_stalled", 32'(rd_cnt - rd_mark), 32'd2);
    check("t2_valid_stalled", 32'(out_valid), 32'd1);
    check("t2_data_stalled", 32'(out_data), 32'h11);
    check("t2_state_run", 32'(dbg_state), 32'(RUN));
    tickn(3);
    check("t2_data_stable", 32'(out_data), 32'h11);
    check("t2_reads_still", 32'(rd_cnt - rd_mark), 32'd2);
    out_ready = 1'b1;
    wait_done("t2_done", 20);
    check("t2_xfer", 32'(xfer_count), 32'd4);
    check("t2_reads", 32'(rd_cnt - rd_mark), 32'd4);
    exp_b(8'h11, 1'b0); exp_b(8'h22, 1'b0); exp_b(8'h33, 1'b0); exp_b(8'h44, 1'b1);
    check_stream("t2_stream");
    tick();

    // T3 FIFO runs empty mid-burst
    push_fifo(8'h55);
    tickn(2);
    rd_mark = rd_cnt;
    start_burst(8'd3);
    tickn(7);
    check("t3_reads_partial", 32'(rd_cnt - rd_mark), 32'd1);
    check("t3_state_run", 32'(dbg_state), 32'(RUN));
    check("t3_got_partial", 32'(got_q.size() - got_base), 32'd1);
    push_fifo(8'h66); push_fifo(8'h77);
    wait_done("t3_done", 20);
    check("t3_no_rd_when_empty", 32'(rd_while_empty), 32'd0);
    check("t3_reads", 32'(rd_cnt - rd_mark), 32'd3);
    check("t3_xfer", 32'(xfer_count), 32'd3);
    exp_b(8'h55, 1'b0); exp_b(8'h66, 1'b0); exp_b(8'h77, 1'b1);
    check_stream("t3_stream");
    tick();

    // T4 abort after the 2nd byte is accepted
    push_fifo(8'h81); push_fifo(8'h82); push_fifo(8'h83); push_fifo(8'h84); push_fifo(8'h85);
    tickn(2);
    rd_mark = rd_cnt;
    start_burst(8'd5);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (got_q.size() - got_base >= 2) begin
        found = 1'b1;
        break;
      end
    end
    check("t4_two_bytes", 32'(found), 32'd1);
    abort = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    rd_abort = rd_cnt;
    check("t4_valid_off", 32'(out_valid), 32'd0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_xfer", 32'(xfer_count), 32'd2);
    check("t4_reads_at_abort", 32'(rd_cnt - rd_mark), 32'd4);
    tickn(3);
    check("t4_no_more_reads", 32'(rd_cnt), 32'(rd_abort));
    check("t4_idle", 32'(busy), 32'd0);
    exp_b(8'h81, 1'b0); exp_b(8'h82, 1'b0);
    check_stream("t4_stream");

    // Byte 0x85 stays in the FIFO; a 1-byte burst collects it.
    out_ready = 1'b1;
    rd_mark = rd_cnt;
    start_burst(8'd1);
    wait_done("t4b_done", 20);
    check("t4b_xfer", 32'(xfer_count), 32'd1);
    check("t4b_reads", 32'(rd_cnt - rd_mark), 32'd1);
    exp_b(8'h85, 1'b1);
    check_stream("t4b_stream");
    tick();

    // T5a zero-length burst
    rd_mark = rd_cnt;
    start_burst(8'd0);
    check("t5_zero_done", 32'(done), 32'd1);
    check("t5_zero_xfer", 32'(xfer_count), 32'd0);
    tick();
    check("t5_zero_idle", 32'(busy), 32'd0);
    check("t5_zero_reads", 32'(rd_cnt - rd_mark), 32'd0);

    // T5b start during RUN ignored
    push_fifo(8'h91); push_fifo(8'h92);
    tickn(2);
    rd_mark = rd_cnt;
    start_burst(8'd2);
    tick();
    start = 1'b1;
    burst_len = 8'd7;
    tick();
    start = 1'b0;
    wait_done("t5_run_done", 20);
    check("t5_run_xfer", 32'(xfer_count), 32'd2);
    check("t5_run_reads", 32'(rd_cnt - rd_mark), 32'd2);
    exp_b(8'h91, 1'b0); exp_b(8'h92, 1'b1);
    check_stream("t5_run_stream");
    tick();
    check("t5_run_idle", 32'(busy), 32'd0);

    // T5c start together with abort in IDLE
    push_fifo(8'hA5);
    tickn(2);
    rd_mark = rd_cnt;
    start = 1'b1;
    burst_len = 8'd1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t5_abort_state", 32'(dbg_state), 32'(IDLE));
    tickn(4);
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_reads", 32'(rd_cnt - rd_mark), 32'd0);
    start_burst(8'd1);
    wait_done("t5_abort_after_done", 20);
    exp_b(8'hA5, 1'b1);
    check_stream("t5_abort_after_stream");
    tick();

    // T6 asynchronous reset while in DRAIN
    push_fifo(8'hC1); push_fifo(8'hC2);
    tickn(2);
    out_ready = 1'b0;
    start_burst(8'd2);
    tickn(3);
    check("t6_state_drain", 32'(dbg_state), 32'(DRAIN));
    check("t6_valid_before", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_done", 32'(done), 32'd0);
    check("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    check("t6_rst_data", 32'(out_data), 32'd0);
    check("t6_rst_xfer", 32'(xfer_count), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'(IDLE));
    tick();
    reset = 1'b1;
    tick();
    got_base = got_q.size();
    push_fifo(8'hD1); push_fifo(8'hD2);
    tickn(2);
    out_ready = 1'b1;
    rd_mark = rd_cnt;
    start_burst(8'd2);
    wait_done("t6_done", 20);
    check("t6_xfer", 32'(xfer_count), 32'd2);
    check("t6_reads", 32'(rd_cnt - rd_mark), 32'd2);
    exp_b(8'hD1, 1'b0); exp_b(8'hD2, 1'b1);
    check_stream("t6_stream");
    tick();
    check("final_no_rd_when_empty", 32'(rd_while_empty), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
